// File: rtl/boreal_pkg.sv
// Shared constants and the state type for the Boreal frame unpacker.
package boreal_pkg;

    localparam int BOREAL_FRAME_W = 792;
    localparam int BOREAL_WORD_W  = 24;
    localparam int BOREAL_NUM_CH  = 32;

    localparam logic [3:0] BOREAL_SYNC_NIBBLE = 4'hC;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } unpack_state_t;

endpackage

// File: rtl/boreal_frame_unpacker.sv
// Boreal frame unpacker: pops one 792-bit frame at a time from a show-ahead
// FIFO, latches its status word, and streams the channel samples as a
// valid/ready stream with channel index and first/last flags.
//
// Optional build macro SYNC_CHECK_EN: when defined, frames whose top status
// nibble is not the sync pattern are popped and dropped, and err_count
// records them. When undefined, every frame streams and err_count stays 0.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no frame held; loads as soon as the FIFO is non-empty
// STREAM | frame_reg holds a frame; beats go out on s_valid & s_ready
module boreal_frame_unpacker
    import boreal_pkg::*;
#(
    parameter int DATA_WIDTH = BOREAL_FRAME_W,
    parameter int WORD_WIDTH = BOREAL_WORD_W,
    parameter int NUM_CH     = BOREAL_NUM_CH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       fifo_dout,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    output logic [WORD_WIDTH-1:0]       status_word,
    output logic                        s_valid,
    input  logic                        s_ready,
    output logic [WORD_WIDTH-1:0]       s_data,
    output logic [$clog2(NUM_CH)-1:0]   s_chan,
    output logic                        s_first,
    output logic                        s_last,
    output logic [15:0]                 frame_count,
    output logic [15:0]                 err_count
);

    localparam int CH_W = $clog2(NUM_CH);

    unpack_state_t state;
    unpack_state_t state_nxt;

    logic [DATA_WIDTH-1:0] frame_reg;
    logic [CH_W-1:0]       chan;
    logic [WORD_WIDTH-1:0] words [NUM_CH];

    logic beat_hs;
    logic last_hs;
    logic load_req;
    logic sync_ok;
    logic load_take;

    // Channel c lives in word c+1; word 0 (the status word) sits at the MSBs.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_words
        assign words[c] = frame_reg[DATA_WIDTH-1-(c+1)*WORD_WIDTH -: WORD_WIDTH];
    end

    // The status word is simply the top word of the held frame, so a dropped
    // frame (never written to frame_reg) cannot disturb it.
    assign status_word = frame_reg[DATA_WIDTH-1 -: WORD_WIDTH];

`ifdef SYNC_CHECK_EN
    assign sync_ok = (fifo_dout[DATA_WIDTH-1 -: 4] == BOREAL_SYNC_NIBBLE);
`else
    assign sync_ok = 1'b1;
`endif

    assign beat_hs = s_valid & s_ready;
    assign last_hs = beat_hs & s_last;

    // A pop happens whenever a frame is wanted and one is present; a frame
    // failing the sync check is still popped, just not taken.
    assign load_req   = !rst && !fifo_empty && ((state == IDLE) || last_hs);
    assign fifo_rd_en = load_req;
    assign load_take  = load_req & sync_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: enter or stay in STREAM only when a good frame is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_take) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (last_hs) begin
                    state_nxt = load_take ? STREAM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stream outputs come straight from the held frame and the channel counter.
    always_comb begin
        s_valid = (state == STREAM);
        s_chan  = chan;
        s_data  = words[chan];
        s_first = s_valid && (chan == '0);
        s_last  = s_valid && (chan == CH_W'(NUM_CH - 1));
    end

    // Frame register, channel counter and completed-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_reg   <= '0;
            chan        <= '0;
            frame_count <= '0;
        end else begin
            if (load_take) begin
                frame_reg <= fifo_dout;
                chan      <= '0;
            end else if (beat_hs) begin
                chan <= s_last ? '0 : chan + 1'b1;
            end
            if (last_hs) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

`ifdef SYNC_CHECK_EN
    // Saturating count of frames dropped for a bad sync nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (load_req && !sync_ok && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_boreal_frame_unpacker.sv
// Self-checking bench for boreal_frame_unpacker. A queue-based show-ahead FIFO
// feeds frames; a reference model derives the expected beat list from each
// frame's contents, and every observed handshake is compared against it.
module tb_boreal_frame_unpacker;

    localparam int DW = 792;
    localparam int WW = 24;
    localparam int NC = 32;

    typedef struct packed {
        logic [WW-1:0] data;
        logic [4:0]    chan;
        logic          first;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [WW-1:0] status_word;
    logic          s_valid;
    logic          s_ready;
    logic [WW-1:0] s_data;
    logic [4:0]    s_chan;
    logic          s_first;
    logic          s_last;
    logic [15:0]   frame_count;
    logic [15:0]   err_count;

    boreal_frame_unpacker dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .status_word (status_word),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_chan      (s_chan),
        .s_first     (s_first),
        .s_last      (s_last),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq [$];
    beat_t         exp_q [$];
    beat_t         obs_q [$];
    int            obs_cyc [$];
    logic [15:0]   exp_fc;
    logic [15:0]   exp_err;
    logic [WW-1:0] exp_status;

    int cyc = 0;
    int pops, rd_empty, rd_rst, valid_cnt, hold_viol, stall_cnt;
    int pop_cyc, first_valid_cyc;
    bit            prev_stall = 0;
    beat_t         prev_beat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic refresh_fifo();
        if (fq.size() != 0) begin
            fifo_dout  = fq[0];
            fifo_empty = 1'b0;
        end else begin
            fifo_dout  = '0;
            fifo_empty = 1'b1;
        end
    endtask

    // Show-ahead FIFO model: pop on a sampled rd_en, present the next entry.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() != 0) begin
            #1;
            void'(fq.pop_front());
            refresh_fifo();
        end
    end

    // Observation of the stream and pop strobes, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t b;
        b = '{data: s_data, chan: s_chan, first: s_first, last: s_last};
        if (fifo_rd_en) begin
            pops++;
            pop_cyc = cyc;
            if (fifo_empty) rd_empty++;
            if (rst) rd_rst++;
        end
        if (s_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (prev_stall && !rst && (!s_valid || b !== prev_beat)) hold_viol++;
        if (s_valid && s_ready) begin
            obs_q.push_back(b);
            obs_cyc.push_back(cyc);
        end
        if (s_valid && !s_ready) stall_cnt++;
        prev_stall = s_valid && !s_ready;
        prev_beat  = b;
    end

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        pops = 0; rd_empty = 0; rd_rst = 0; valid_cnt = 0;
        hold_viol = 0; stall_cnt = 0;
        pop_cyc = -1; first_valid_cyc = -1;
    endtask

    function automatic logic [DW-1:0] make_frame(input logic [WW-1:0] st, input bit directed);
        logic [DW-1:0] f;
        f = '0;
        f[DW-1 -: WW] = st;
        for (int c = 0; c < NC; c++) begin
            if (directed) f[DW-1-(c+1)*WW -: WW] = (c == NC-1) ? 24'h800000 : WW'(c + 1);
            else          f[DW-1-(c+1)*WW -: WW] = WW'($urandom);
        end
        return f;
    endfunction

    // Reference model: a frame either yields its 32 samples in order or,
    // with the sync check built in and a bad nibble, is counted as dropped.
    task automatic push_frame(input logic [DW-1:0] f);
        bit good;
        beat_t b;
`ifdef SYNC_CHECK_EN
        good = (f[DW-1 -: 4] == 4'hC);
`else
        good = 1'b1;
`endif
        if (good) begin
            for (int c = 0; c < NC; c++) begin
                b.data  = f[DW-1-(c+1)*WW -: WW];
                b.chan  = 5'(c);
                b.first = (c == 0);
                b.last  = (c == NC-1);
                exp_q.push_back(b);
            end
            exp_fc     = exp_fc + 16'd1;
            exp_status = f[DW-1 -: WW];
        end else if (exp_err != 16'hFFFF) begin
            exp_err = exp_err + 16'd1;
        end
        fq.push_back(f);
        refresh_fifo();
    endtask

    // Drives s_ready each cycle until the stream drains; mode 0 = always
    // ready, 1 = random, 2 = stall 5 cycles at chan 7 then toggle.
    task automatic run_stream(input int budget, input int mode, output bit timeout);
        int bp_phase = 0;
        int bp_n = 0;
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            case (mode)
                1: s_ready = ($urandom_range(0, 9) < 7);
                2: begin
                    if (bp_phase == 0 && s_valid && s_chan == 5'd7) bp_phase = 1;
                    if (bp_phase == 1) begin
                        s_ready = 1'b0;
                        bp_n++;
                        if (bp_n == 5) bp_phase = 2;
                    end else if (bp_phase == 2) begin
                        s_ready = ~s_ready;
                    end else begin
                        s_ready = 1'b1;
                    end
                end
                default: s_ready = 1'b1;
            endcase
            if (obs_q.size() >= exp_q.size() && fq.size() == 0 && !s_valid) begin
                timeout = 1'b0;
                break;
            end
        end
        s_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_ready = 1'b1;
        fq.push_back(make_frame(24'hC00000, 1'b1));
        refresh_fifo();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset rd_en: got %b expected 0", fifo_rd_en); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset s_valid: got %b expected 0", s_valid); end
        checks++; if ({s_first, s_last} !== 2'b00) begin errors++; $display("FAIL reset first/last: got %b expected 00", {s_first, s_last}); end
        checks++; if (s_chan !== 5'd0 || s_data !== '0) begin errors++; $display("FAIL reset chan/data: got %0d/%h expected 0/0", s_chan, s_data); end
        checks++; if (status_word !== '0) begin errors++; $display("FAIL reset status_word: got %h expected 0", status_word); end
        checks++; if (frame_count !== 16'd0 || err_count !== 16'd0) begin errors++; $display("FAIL reset counters: got %0d/%0d expected 0/0", frame_count, err_count); end
        fq.delete();
        refresh_fifo();
        exp_fc = 0; exp_err = 0; exp_status = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit to;
        clear_obs();
        push_frame(make_frame(24'hC00000, 1'b1));
        run_stream(400, 0, to);
        checks++; if (to) begin errors++; $display("FAIL single timeout: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        checks++; if (pops !== 1) begin errors++; $display("FAIL single pops: got %0d expected 1", pops); end
        checks++; if (first_valid_cyc - pop_cyc !== 1) begin errors++; $display("FAIL single latency: got %0d expected 1", first_valid_cyc - pop_cyc); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL single beat count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single beat %0d: got %h/%0d/%b%b expected %h/%0d/%b%b", i,
                         obs_q[i].data, obs_q[i].chan, obs_q[i].first, obs_q[i].last,
                         exp_q[i].data, exp_q[i].chan, exp_q[i].first, exp_q[i].last);
            end
        end
        checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL single frame_count: got %0d expected %0d", frame_count, exp_fc); end
    endtask

    task automatic test_backpressure();
        bit to;
        clear_obs();
        push_frame(make_frame(24'hC0BEEF, 1'b0));
        run_stream(400, 2, to);
        checks++; if (to) begin errors++; $display("FAIL bp timeout: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        checks++; if (stall_cnt < 5) begin errors++; $display("FAIL bp stalls: got %0d expected at least 5", stall_cnt); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp hold: got %0d violations expected 0", hold_viol); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp beat count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp beat %0d: got %h/%0d expected %h/%0d", i,
                         obs_q[i].data, obs_q[i].chan, exp_q[i].data, exp_q[i].chan);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int bubbles = 0;
        clear_obs();
        push_frame(make_frame(24'hC00A00 | 24'($urandom_range(0, 255)), 1'b0));
        push_frame(make_frame(24'hC00B00 | 24'($urandom_range(0, 255)), 1'b0));
        run_stream(400, 0, to);
        checks++; if (to) begin errors++; $display("FAIL b2b timeout: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        checks++; if (obs_q.size() !== 2*NC) begin errors++; $display("FAIL b2b beat count: got %0d expected %0d", obs_q.size(), 2*NC); end
        for (int i = 1; i < obs_cyc.size(); i++) if (obs_cyc[i] - obs_cyc[i-1] != 1) bubbles++;
        checks++; if (bubbles !== 0) begin errors++; $display("FAIL b2b bubbles: got %0d expected 0", bubbles); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b beat %0d: got %h/%0d expected %h/%0d", i,
                         obs_q[i].data, obs_q[i].chan, exp_q[i].data, exp_q[i].chan);
            end
        end
        checks++; if (pops !== 2) begin errors++; $display("FAIL b2b pops: got %0d expected 2", pops); end
        checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL b2b frame_count: got %0d expected %0d", frame_count, exp_fc); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL b2b idle: got s_valid=%b expected 0", s_valid); end
    endtask

    task automatic test_idle();
        clear_obs();
        repeat (100) @(posedge clk);
        #1;
        checks++; if (pops !== 0) begin errors++; $display("FAIL idle pops: got %0d expected 0", pops); end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL idle valid: got %0d cycles expected 0", valid_cnt); end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit seen = 1'b0;
        int pops_at;
        clear_obs();
        push_frame(make_frame(24'hC01111, 1'b0));
        push_frame(make_frame(24'hC02222, 1'b0));
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (s_valid && s_chan == 5'd10) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid reach chan10: got no beat at chan 10 expected one"); end
        rst = 1'b1;
        pops_at = pops;
        @(negedge clk);
        checks++; if (s_valid !== 1'b0 || s_chan !== 5'd0) begin errors++; $display("FAIL rstmid outputs: got valid=%b chan=%0d expected 0/0", s_valid, s_chan); end
        checks++; if (frame_count !== 16'd0 || err_count !== 16'd0) begin errors++; $display("FAIL rstmid counters: got %0d/%0d expected 0/0", frame_count, err_count); end
        @(negedge clk);
        checks++; if (pops !== pops_at || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid pop in reset: got %0d pops rd_en=%b expected 0 pops", pops - pops_at, fifo_rd_en); end
        repeat (NC) void'(exp_q.pop_front());
        exp_fc = 16'd1; exp_err = 16'd0; exp_status = 24'hC02222;
        obs_q.delete(); obs_cyc.delete();
        rst = 1'b0;
        run_stream(400, 0, to);
        checks++; if (to || obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid beat count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid beat %0d: got %h/%0d expected %h/%0d", i,
                         obs_q[i].data, obs_q[i].chan, exp_q[i].data, exp_q[i].chan);
            end
        end
        checks++; if (frame_count !== exp_fc || status_word !== exp_status) begin errors++; $display("FAIL rstmid after: got fc=%0d st=%h expected fc=%0d st=%h", frame_count, status_word, exp_fc, exp_status); end
    endtask

    task automatic test_sync();
        bit to;
        clear_obs();
        push_frame(make_frame(24'h300000, 1'b0));
        push_frame(make_frame(24'hC00001, 1'b0));
        run_stream(400, 0, to);
        checks++; if (to) begin errors++; $display("FAIL sync timeout: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        checks++; if (pops !== 2) begin errors++; $display("FAIL sync pops: got %0d expected 2", pops); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL sync beat count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sync beat %0d: got %h/%0d expected %h/%0d", i,
                         obs_q[i].data, obs_q[i].chan, exp_q[i].data, exp_q[i].chan);
            end
        end
        checks++; if (err_count !== exp_err) begin errors++; $display("FAIL sync err_count: got %0d expected %0d", err_count, exp_err); end
        checks++; if (status_word !== exp_status) begin errors++; $display("FAIL sync status_word: got %h expected %h", status_word, exp_status); end
        checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL sync frame_count: got %0d expected %0d", frame_count, exp_fc); end
    endtask

    task automatic test_random();
        bit to;
        logic [WW-1:0] st;
        clear_obs();
        for (int n = 0; n < 6; n++) begin
            st = WW'($urandom);
            if ($urandom_range(0, 3) != 0) st[WW-1 -: 4] = 4'hC;
            push_frame(make_frame(st, 1'b0));
        end
        run_stream(2000, 1, to);
        checks++; if (to || obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL random beat count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random beat %0d: got %h/%0d/%b%b expected %h/%0d/%b%b", i,
                         obs_q[i].data, obs_q[i].chan, obs_q[i].first, obs_q[i].last,
                         exp_q[i].data, exp_q[i].chan, exp_q[i].first, exp_q[i].last);
            end
        end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL random hold: got %0d violations expected 0", hold_viol); end
        checks++; if (pops !== 6 || rd_empty !== 0) begin errors++; $display("FAIL random pops: got %0d (%0d on empty) expected 6 (0)", pops, rd_empty); end
        checks++; if (frame_count !== exp_fc || err_count !== exp_err) begin errors++; $display("FAIL random counters: got %0d/%0d expected %0d/%0d", frame_count, err_count, exp_fc, exp_err); end
        checks++; if (status_word !== exp_status) begin errors++; $display("FAIL random status_word: got %h expected %h", status_word, exp_status); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fifo_dout  = '0;
        fifo_empty = 1'b1;
        clear_obs();
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        test_sync();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boreal_frame_unpacker.md
Name: boreal_frame_unpacker

Overview:
Read-side consumer of the 792-bit SPI payload FIFO in the 100MHz Active Inference domain. Pops one frame at a time from the FIFO's show-ahead read port and latches the 24-bit status word. Emits the 32 channel samples as a valid/ready stream of signed 24-bit words tagged with channel index, first and last flags. Keeps a running frame counter.

Parameters:
DATA_WIDTH, 792, FIFO payload width; must equal WORD_WIDTH*(NUM_CH+1)
WORD_WIDTH, 24, width of the status word and of each channel sample
NUM_CH, 32, channel samples per frame; the 5-bit channel index is derived as clog2(NUM_CH)

Ports:
clk  in  1  system clock, 100MHz
rst  in  1  synchronous, active-high reset
fifo_dout  in  DATA_WIDTH  FIFO show-ahead data; valid whenever fifo_empty=0
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO pop strobe; combinational, one cycle per frame
status_word  out  WORD_WIDTH  status word of the frame currently being streamed
s_valid  out  1  sample valid
s_ready  in  1  downstream ready
s_data  out  WORD_WIDTH  signed channel sample (two's complement, passed through unchanged)
s_chan  out  5  channel index 0..NUM_CH-1
s_first  out  1  high on the beat with s_chan=0
s_last  out  1  high on the beat with s_chan=NUM_CH-1
frame_count  out  16  number of frames fully streamed; wraps 0xFFFF->0
err_count  out  16  number of frames dropped on sync error; saturates at 0xFFFF

Behaviour:
- Frame layout: word k sits at bits [DATA_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH], MSB-first. Word 0 is the status word. Word c+1 is channel c.
- Reset (sync, rst=1 at clk edge) puts the block in this state:
  - state IDLE
  - s_valid, fifo_rd_en, s_first, s_last = 0
  - s_chan = 0; s_data, status_word, frame_reg = 0
  - frame_count, err_count = 0
- While rst=1, fifo_rd_en=0 regardless of fifo_empty.
- Reset mid-frame abandons the frame with no further beats. The FIFO entry was already popped at load.
- Load condition: (state==IDLE, or the last-beat handshake s_valid&s_ready&s_last occurs) and fifo_empty=0.
  - On load, fifo_rd_en=1 in that same cycle.
  - The full fifo_dout is registered into frame_reg.
  - status_word is updated and the channel counter is set to 0.
- States are IDLE and STREAM.
  - IDLE -> STREAM on load.
  - In STREAM, the last-beat handshake either loads the next frame (stay in STREAM, chan=0) or, if fifo_empty=1, goes to IDLE.
- Latency: s_valid rises on the cycle after the load. Back-to-back frames stream with zero bubbles, giving 32 beats per 32 cycles at s_ready=1.
- Handshake: s_data, s_chan, s_first and s_last are driven from frame_reg and the counter.
  - When s_valid=1 and s_ready=0, they hold stable and s_valid stays 1.
  - The counter advances only on s_valid&s_ready.
- frame_count increments on each last-beat handshake.
- fifo_rd_en is never asserted when fifo_empty=1. There is at most one pop per frame.

Optional Feature:
Macro SYNC_CHECK_EN.
- Defined: at load, fifo_dout status nibble [DATA_WIDTH-1 -: 4] must equal 4'hC.
  - On a mismatch, the frame is still popped (fifo_rd_en=1).
  - No beats are emitted and status_word is not updated.
  - err_count increments (saturating) and the block goes to or stays in IDLE.
  - A new load is evaluated on the next cycle.
- Undefined: no check is made, every frame streams, and err_count is constant 0.

Decomposition:
- Package boreal_pkg holds:
  - BOREAL_FRAME_W=792, BOREAL_WORD_W=24, BOREAL_NUM_CH=32
  - BOREAL_SYNC_NIBBLE=4'hC
  - the unpacker state typedef {IDLE, STREAM}
- No sub-module. The word-select mux and counter stay inline.

Test Plan:
1. Single frame: status=0xC00000, ch c=c+1, ch31=0x800000, s_ready=1 -> exactly one fifo_rd_en pulse; s_valid first high 1 cycle later; 32 beats with s_chan 0..31; s_first only on beat 0, s_last only on beat 31; ch31 s_data=0x800000; frame_count=1.
2. Backpressure: hold s_ready=0 for 5 cycles at chan 7, then toggle 1/0 -> s_data, s_chan held stable; no skipped or duplicated channel; still 32 beats.
3. Back-to-back: 2 frames queued, s_ready=1 -> 64 consecutive beats with no bubble, 2 pops, frame_count=2; IDLE after the second s_last.
4. Empty/idle: fifo_empty=1 for 100 cycles -> fifo_rd_en=0, s_valid=0 throughout.
5. Reset mid-stream: rst=1 at chan 10 -> next cycle s_valid=0, counters 0, no pop during reset; the next queued frame streams normally after rst drops.
6. SYNC_CHECK_EN: frames with status 0x300000 then 0xC00001 -> with macro: both popped, only the second streams, err_count=1, status_word=0xC00001. Without macro: both stream, err_count=0, frame_count=2.
